// File: rtl/lbuf_wr_addr_pkg.sv
// Shared constants for the line-buffer write-address sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lbuf_wr_addr_pkg;

    // Sequencer state encoding
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } lbuf_state_t;

    // Default block geometry
    localparam int          AW_DEF    = 9;
    localparam int          LEN_W_DEF = 10;
    localparam int          DW_DEF    = 16;
    localparam logic [8:0]  X_MAX_DEF = 9'd359;

    // TOM line-buffer sizing: physical depth and visible span
    localparam int          TOM_LBUF_DEPTH   = 512;
    localparam int          TOM_LBUF_VISIBLE = 360;

endpackage

// File: rtl/lbuf_addr_step.sv
// Combinational AW-bit +/-ci address step built from a half-adder carry chain.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the result is always valid for the current inputs.
module lbuf_addr_step
    import lbuf_wr_addr_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] a,
    input  logic          refl,
    input  logic          ci,
    output logic [AW-1:0] q
);

    logic [AW-1:0] b;
    logic [AW-1:0] s;
    logic [AW-1:0] c;

    // Decrement is computed as ~(~a + ci), so one incrementer chain serves both directions
    assign b    = a ^ {AW{refl}};
    assign c[0] = ci;

    for (genvar i = 0; i < AW; i++) begin : g_ha
        assign s[i] = b[i] ^ c[i];
        if (i < AW - 1) begin : g_carry
            assign c[i+1] = b[i] & c[i];
        end
    end

    // Carry out of the top bit is dropped: arithmetic wraps modulo 2**AW
    assign q = s ^ {AW{refl}};

endmodule

// File: rtl/lbuf_wr_addr.sv
// Line-buffer write-address sequencer: one registered write per accepted pixel, address +/-1 with wrap.
// Latency: 1 cycle from pixel handshake to wr_en/wr_addr/wr_data; done pulses with the last write.
// Backpressure: pix_ready high throughout a run, low when idle; clipping (LBUF_CLIP_EN) suppresses writes beyond X_MAX.
module lbuf_wr_addr
    import lbuf_wr_addr_pkg::*;
#(
    parameter int            AW    = AW_DEF,
    parameter int            LEN_W = LEN_W_DEF,
    parameter int            DW    = DW_DEF,
    parameter logic [AW-1:0] X_MAX = X_MAX_DEF
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             ld,
    input  logic [AW-1:0]    ld_x,
    input  logic [LEN_W-1:0] ld_n,
    input  logic             ld_refl,
    input  logic             pix_valid,
    input  logic [DW-1:0]    pix_data,
    output logic             pix_ready,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [DW-1:0]    wr_data,
    output logic             busy,
    output logic             done
);

`ifdef LBUF_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    lbuf_state_t      state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             refl_q, refl_d;
    logic             done_d;
    logic             wr_en_d;
    logic             xfer;
    logic             clip;
    logic [AW-1:0]    addr_step;

    lbuf_addr_step #(
        .AW (AW)
    ) u_step (
        .a    (addr_q),
        .refl (refl_q),
        .ci   (1'b1),
        .q    (addr_step)
    );

    assign pix_ready = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign xfer      = pix_valid && pix_ready;
    assign clip      = CLIP_EN && (addr_q > X_MAX);

    // Next state: advance on transfer, then let a load (abort/reload) override
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        refl_d  = refl_q;
        done_d  = 1'b0;
        wr_en_d = xfer && !clip;
        if (xfer) begin
            addr_d = addr_step;
            rem_d  = rem_q - LEN_W'(1);
        end
        if (ld) begin
            if (ld_n != '0) begin
                state_d = ST_RUN;
                addr_d  = ld_x;
                rem_d   = ld_n;
                refl_d  = ld_refl;
            end else begin
                state_d = ST_IDLE;
                rem_d   = '0;
                done_d  = 1'b1;
            end
        end else if (xfer && (rem_q == LEN_W'(1))) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end
    end

    // State register and run context
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            refl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            refl_q  <= refl_d;
        end
    end

    // Write port and done registers; address/data hold between writes
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            wr_en <= wr_en_d;
            done  <= done_d;
            if (wr_en_d) begin
                wr_addr <= addr_q;
                wr_data <= pix_data;
            end
        end
    end

endmodule

// File: tb/tb_lbuf_wr_addr.sv
module tb_lbuf_wr_addr;

    typedef struct {
        logic [8:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        sys_clk = 1'b0;
    logic        resetl;
    logic        ld;
    logic [8:0]  ld_x;
    logic [9:0]  ld_n;
    logic        ld_refl;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic        m_run;
    logic [8:0]  m_addr;
    logic [9:0]  m_rem;
    logic        m_refl;
    logic [8:0]  m_wa;
    logic [15:0] m_wd;
    wr_t         sb[$];
    logic [8:0]  wlog[$];

    lbuf_wr_addr dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .ld        (ld),
        .ld_x      (ld_x),
        .ld_n      (ld_n),
        .ld_refl   (ld_refl),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic model_reset();
        m_run  = 1'b0;
        m_addr = '0;
        m_rem  = '0;
        m_refl = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
        sb.delete();
    endtask

    // One clock cycle: drive inputs, predict, clock, compare at the falling edge
    task automatic step(input logic l, input logic [8:0] x, input logic [9:0] n,
                        input logic r, input logic pv);
        logic xfer;
        logic exp_done;
        wr_t  e;
        ld        = l;
        ld_x      = x;
        ld_n      = n;
        ld_refl   = r;
        pix_valid = pv;
        pix_data  = 16'($urandom);
        checks++;
        if (pix_ready !== m_run) begin
            errors++;
            $display("FAIL pix_ready got %b exp %b", pix_ready, m_run);
        end
        checks++;
        if (busy !== m_run) begin
            errors++;
            $display("FAIL busy got %b exp %b", busy, m_run);
        end
        xfer     = pv && m_run;
        exp_done = 1'b0;
        if (xfer) begin
`ifdef LBUF_CLIP_EN
            if (m_addr <= 9'd359) begin
                e.a = m_addr; e.d = pix_data; sb.push_back(e);
                m_wa = m_addr; m_wd = pix_data;
            end
`else
            e.a = m_addr; e.d = pix_data; sb.push_back(e);
            m_wa = m_addr; m_wd = pix_data;
`endif
            m_addr = m_refl ? m_addr - 9'd1 : m_addr + 9'd1;
            m_rem  = m_rem - 10'd1;
        end
        if (l) begin
            if (n != 10'd0) begin
                m_run = 1'b1; m_addr = x; m_rem = n; m_refl = r;
            end else begin
                m_run = 1'b0; exp_done = 1'b1;
            end
        end else if (xfer && m_rem == 10'd0) begin
            m_run = 1'b0; exp_done = 1'b1;
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        ld        = 1'b0;
        pix_valid = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== e.a || wr_data !== e.d) begin
                errors++;
                $display("FAIL write got en=%b a=%h d=%h exp en=1 a=%h d=%h",
                         wr_en, wr_addr, wr_data, e.a, e.d);
            end
        end else begin
            checks++;
            if (wr_en !== 1'b0 || wr_addr !== m_wa || wr_data !== m_wd) begin
                errors++;
                $display("FAIL idle_write got en=%b a=%h d=%h exp en=0 a=%h d=%h",
                         wr_en, wr_addr, wr_data, m_wa, m_wd);
            end
        end
        if (wr_en === 1'b1) wlog.push_back(wr_addr);
        checks++;
        if (done !== exp_done) begin
            errors++;
            $display("FAIL done got %b exp %b", done, exp_done);
        end
    endtask

    task automatic test_reset();
        resetl = 1'b0; ld = 0; ld_x = 0; ld_n = 0; ld_refl = 0; pix_valid = 0; pix_data = 0;
        model_reset();
        #3;
        checks++;
        if ({wr_en, wr_addr, wr_data, busy, done, pix_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b a=%h d=%h busy=%b done=%b rdy=%b exp all 0",
                     wr_en, wr_addr, wr_data, busy, done, pix_ready);
        end
        @(negedge sys_clk);
        resetl = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_incr();
        logic [8:0] exp[4] = '{9'h010, 9'h011, 9'h012, 9'h013};
        wlog.delete();
        step(1, 9'h010, 10'd4, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        checks++;
        if (wlog.size() != 4) begin
            errors++;
            $display("FAIL incr_count got %0d exp 4", wlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wlog[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL incr_addr[%0d] got %h exp %h", i, wlog[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [8:0] exp[6] = '{9'h001, 9'h000, 9'h1FF, 9'h1FE, 9'h1FF, 9'h000};
        wlog.delete();
        step(1, 9'h001, 10'd3, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        step(1, 9'h1FE, 10'd3, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        checks++;
        if (wlog.size() != 6) begin
            errors++;
            $display("FAIL wrap_count got %0d exp 6", wlog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wlog[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d] got %h exp %h", i, wlog[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        wlog.delete();
        step(1, 9'h0AA, 10'd0, 0, 1);
        step(0, 0, 0, 0, 1);
        checks++;
        if (wlog.size() != 0) begin
            errors++;
            $display("FAIL zero_len_writes got %0d exp 0", wlog.size());
        end
    endtask

    task automatic test_stall_hold();
        wlog.delete();
        step(1, 9'h040, 10'd8, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, (i % 2) == 0);
        step(1, 9'h0C0, 10'd2, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        checks++;
        if (wlog.size() != 10) begin
            errors++;
            $display("FAIL stall_count got %0d exp 10", wlog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wlog[i] !== 9'h040 + 9'(i)) begin
                    errors++;
                    $display("FAIL stall_addr[%0d] got %h exp %h", i, wlog[i], 9'h040 + 9'(i));
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [8:0] exp[6] = '{9'h100, 9'h101, 9'h102, 9'h103, 9'h020, 9'h021};
        wlog.delete();
        step(1, 9'h100, 10'd8, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        step(1, 9'h020, 10'd2, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        checks++;
        if (wlog.size() != 6) begin
            errors++;
            $display("FAIL abort_count got %0d exp 6", wlog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wlog[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL abort_addr[%0d] got %h exp %h", i, wlog[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_clip();
`ifdef LBUF_CLIP_EN
        int exp_n = 2;
`else
        int exp_n = 4;
`endif
        wlog.delete();
        step(1, 9'h166, 10'd4, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        checks++;
        if (wlog.size() != exp_n) begin
            errors++;
            $display("FAIL clip_count got %0d exp %0d", wlog.size(), exp_n);
        end
    endtask

    task automatic test_async_reset();
        step(1, 9'h050, 10'd5, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        #2;
        resetl = 1'b0;
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, busy, done, pix_ready} !== '0) begin
            errors++;
            $display("FAIL async_reset got en=%b a=%h d=%h busy=%b done=%b rdy=%b exp all 0",
                     wr_en, wr_addr, wr_data, busy, done, pix_ready);
        end
        model_reset();
        @(negedge sys_clk);
        resetl = 1'b1;
        wlog.delete();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        checks++;
        if (wlog.size() != 0) begin
            errors++;
            $display("FAIL post_reset_writes got %0d exp 0", wlog.size());
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_zero_len();
        test_stall_hold();
        test_abort();
        test_clip();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
